// File: rtl/fpu_types_pkg.sv
// fpu_types_pkg: shared FPU format constants and the min/max reduction state type
package fpu_types_pkg;
  localparam int HALF_FLOAT_W = 16;
  localparam int HALF_EXPONENT_W = 5;
  localparam int HALF_FRACTION_W = 10;
  localparam logic [15:0] HALF_NAN = 16'h7E00;
  localparam int SINGLE_FLOAT_W = 32;
  localparam int SINGLE_EXPONENT_W = 8;
  localparam int SINGLE_FRACTION_W = 23;
  localparam logic [31:0] SINGLE_NAN = 32'h7FC0_0000;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} red_state_t;
endpackage

// File: rtl/float_minmax_cmp.sv
// float_minmax_cmp: RISC-V fmin/fmax of a and b (max=1 selects max); res is the pick, nv flags an sNaN operand
module float_minmax_cmp import fpu_types_pkg::*; #(
  parameter int FLOAT_WIDTH = HALF_FLOAT_W,
  parameter int EXPONENT_WIDTH = HALF_EXPONENT_W,
  parameter int FRACTION_WIDTH = HALF_FRACTION_W
) (
  input  logic [FLOAT_WIDTH-1:0] a,
  input  logic [FLOAT_WIDTH-1:0] b,
  input  logic                   max,
  output logic [FLOAT_WIDTH-1:0] res,
  output logic                   nv
);
  localparam logic [FLOAT_WIDTH-1:0] CNAN = {1'b0, {EXPONENT_WIDTH{1'b1}}, 1'b1, {(FRACTION_WIDTH-1){1'b0}}};
  logic w_a_nan, w_b_nan, w_a_lt;
  always_comb begin
    w_a_nan = &a[FLOAT_WIDTH-2:FRACTION_WIDTH] && |a[FRACTION_WIDTH-1:0];
    w_b_nan = &b[FLOAT_WIDTH-2:FRACTION_WIDTH] && |b[FRACTION_WIDTH-1:0];
    nv = (w_a_nan && !a[FRACTION_WIDTH-1]) || (w_b_nan && !b[FRACTION_WIDTH-1]);
    w_a_lt = (a[FLOAT_WIDTH-1] != b[FLOAT_WIDTH-1]) ? a[FLOAT_WIDTH-1] :
             a[FLOAT_WIDTH-1] ? (a[FLOAT_WIDTH-2:0] > b[FLOAT_WIDTH-2:0]) : (a[FLOAT_WIDTH-2:0] < b[FLOAT_WIDTH-2:0]);
    res = (w_a_nan && w_b_nan) ? CNAN :
          w_a_nan ? b :
          w_b_nan ? a :
          (max ^ w_a_lt) ? a : b;
  end
endmodule

// File: rtl/float_minmax_reduce.sv
// float_minmax_reduce: streaming min/max reduction; in_* beats feed the accumulator, out_* returns data/nv/count per vector
module float_minmax_reduce import fpu_types_pkg::*; #(
  parameter int FLOAT_WIDTH = HALF_FLOAT_W,
  parameter int EXPONENT_WIDTH = HALF_EXPONENT_W,
  parameter int FRACTION_WIDTH = HALF_FRACTION_W,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FLOAT_WIDTH-1:0] in_data,
  input  logic                   in_last,
  input  logic                   in_max,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FLOAT_WIDTH-1:0] out_data,
  output logic                   out_nv,
  output logic [COUNT_WIDTH-1:0] out_count
);
  localparam logic [FLOAT_WIDTH-1:0] CNAN = {1'b0, {EXPONENT_WIDTH{1'b1}}, 1'b1, {(FRACTION_WIDTH-1){1'b0}}};
  red_state_t r_state, w_next;
  logic [FLOAT_WIDTH-1:0] r_acc, w_acc_in, w_res;
  logic [COUNT_WIDTH-1:0] r_cnt;
  logic r_mode, r_nv, w_mode, w_nv, w_beat, w_idle;
  assign in_ready = r_state != DONE;
  assign out_valid = r_state == DONE;
  assign out_data = r_acc;
  assign out_nv = r_nv;
  assign out_count = r_cnt;
  assign w_beat = in_valid && in_ready;
  assign w_idle = r_state == IDLE;
  // the identity NaN is substituted on the opening beat, so a stale accumulator never leaks into a new vector
  assign w_acc_in = w_idle ? CNAN : r_acc;
  assign w_mode = w_idle ? in_max : r_mode;
  float_minmax_cmp #(
    .FLOAT_WIDTH(FLOAT_WIDTH),
    .EXPONENT_WIDTH(EXPONENT_WIDTH),
    .FRACTION_WIDTH(FRACTION_WIDTH)
  ) u_cmp (
    .a(w_acc_in),
    .b(in_data),
    .max(w_mode),
    .res(w_res),
    .nv(w_nv)
  );
  always_ff @(posedge CLK or posedge RST)
    if (RST) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_beat) w_next = in_last ? DONE : ACCUM;
    else if (r_state == DONE && out_ready) w_next = IDLE;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_acc <= CNAN;
      r_mode <= 1'b0;
      r_nv <= 1'b0;
      r_cnt <= '0;
    end else if (w_beat) begin
      r_acc <= w_res;
      r_mode <= w_mode;
      r_nv <= (!w_idle && r_nv) || w_nv;
      r_cnt <= w_idle ? COUNT_WIDTH'(1) : (&r_cnt ? r_cnt : r_cnt + COUNT_WIDTH'(1));
    end
endmodule

// File: tb/tb_float_minmax_reduce.sv
// tb_float_minmax_reduce: randomized and directed checks of half- and single-precision reducers against a value-level model
module tb_float_minmax_reduce;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  bit sel;
  logic in_valid, in_last, in_max, out_ready;
  logic [31:0] in_data;
  logic h_ir, h_ov, h_nv, s_ir, s_ov, s_nv;
  logic [15:0] h_od;
  logic [31:0] s_od;
  logic [1:0] h_cnt;
  logic [3:0] s_cnt;
  logic o_ir, o_ov, o_nv;
  logic [31:0] o_d;
  int o_cnt;
  int total = 0;
  int bad = 0;

  float_minmax_reduce #(.FLOAT_WIDTH(16), .EXPONENT_WIDTH(5), .FRACTION_WIDTH(10), .COUNT_WIDTH(2)) u_half (
    .CLK(clk), .RST(rst), .in_valid(in_valid && !sel), .in_ready(h_ir), .in_data(in_data[15:0]),
    .in_last(in_last), .in_max(in_max), .out_valid(h_ov), .out_ready(out_ready && !sel),
    .out_data(h_od), .out_nv(h_nv), .out_count(h_cnt));
  float_minmax_reduce #(.FLOAT_WIDTH(32), .EXPONENT_WIDTH(8), .FRACTION_WIDTH(23), .COUNT_WIDTH(4)) u_single (
    .CLK(clk), .RST(rst), .in_valid(in_valid && sel), .in_ready(s_ir), .in_data(in_data),
    .in_last(in_last), .in_max(in_max), .out_valid(s_ov), .out_ready(out_ready && sel),
    .out_data(s_od), .out_nv(s_nv), .out_count(s_cnt));

  always_comb begin
    o_ir = sel ? s_ir : h_ir;
    o_ov = sel ? s_ov : h_ov;
    o_nv = sel ? s_nv : h_nv;
    o_d = sel ? s_od : {16'h0, h_od};
    o_cnt = sel ? int'(s_cnt) : int'(h_cnt);
  end

  function automatic int ew(); return sel ? 8 : 5; endfunction
  function automatic int fw(); return sel ? 23 : 10; endfunction
  function automatic int cw(); return sel ? 4 : 2; endfunction
  function automatic logic [31:0] cnan();
    return 32'((((1 << ew()) - 1) << fw()) | (1 << (fw() - 1)));
  endfunction
  function automatic bit sgn(logic [31:0] x); return x[ew() + fw()]; endfunction
  function automatic int expf(logic [31:0] x); return int'((x >> fw()) & ((1 << ew()) - 1)); endfunction
  function automatic int frac(logic [31:0] x); return int'(x & ((1 << fw()) - 1)); endfunction
  function automatic bit isnan(logic [31:0] x); return expf(x) == (1 << ew()) - 1 && frac(x) != 0; endfunction
  function automatic bit issnan(logic [31:0] x); return isnan(x) && frac(x) < (1 << (fw() - 1)); endfunction
  function automatic real pow2(int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else repeat (-n) r = r / 2.0;
    return r;
  endfunction
  function automatic real fval(logic [31:0] x);
    int ex = expf(x);
    int bias = (1 << (ew() - 1)) - 1;
    real m;
    if (ex == (1 << ew()) - 1) m = 1.0e300;
    else if (ex == 0) m = real'(frac(x)) * pow2(1 - bias - fw());
    else m = (1.0 + real'(frac(x)) * pow2(-fw())) * pow2(ex - bias);
    return sgn(x) ? -m : m;
  endfunction
  function automatic bit better(logic [31:0] x, logic [31:0] y, bit mx);
    real a = fval(x);
    real b = fval(y);
    if (a == b) return a == 0.0 && (mx ? (!sgn(x) && sgn(y)) : (sgn(x) && !sgn(y)));
    return mx ? a > b : a < b;
  endfunction
  function automatic logic [31:0] h2s(logic [15:0] h);
    int ex = int'(h[14:10]);
    return {h[15], ex == 0 ? 8'd0 : ex == 31 ? 8'hFF : 8'(ex + 112), h[9:0], 13'd0};
  endfunction
  function automatic logic [31:0] conv(logic [31:0] x); return sel ? h2s(x[15:0]) : x; endfunction
  function automatic logic [31:0] rnd_elem();
    logic [31:0] sp [6] = '{32'h0000, 32'h8000, 32'h7C00, 32'hFC00, 32'h7E00, 32'h7D00};
    if ($urandom_range(0, 2) == 0) return conv(sp[$urandom_range(0, 5)]);
    return sel ? $urandom : {16'h0, 16'($urandom)};
  endfunction

  task automatic model(input logic [31:0] v[$], input bit mx, output logic [31:0] r, output bit nv, output int cnt);
    bit have = 0;
    r = cnan();
    nv = 0;
    foreach (v[i]) begin
      if (issnan(v[i])) nv = 1;
      if (!isnan(v[i])) begin
        if (!have || better(v[i], r, mx)) r = v[i];
        have = 1;
      end
    end
    cnt = v.size() > (1 << cw()) - 1 ? (1 << cw()) - 1 : v.size();
  endtask

  task automatic run_vector(input logic [31:0] v[$], input bit mx, output logic [31:0] d, output bit nv,
                            output int cnt, output bit lat_ok, output bit stab_ok);
    int i = 0;
    int g = 0;
    stab_ok = 1;
    while (i < v.size() && g < 400) begin
      @(negedge clk);
      g++;
      if (i > 0 && $urandom_range(0, 3) == 0) begin
        in_valid = 0; in_data = $urandom; in_last = 1'($urandom); in_max = 1'($urandom);
      end else begin
        in_valid = 1; in_data = v[i]; in_last = (i == v.size() - 1); in_max = (i == 0) ? mx : 1'($urandom);
        if (o_ir) i++;
      end
    end
    @(negedge clk);
    in_valid = 0;
    lat_ok = o_ov;
    g = 0;
    while (!o_ov && g < 20) begin @(negedge clk); g++; end
    d = o_d; nv = o_nv; cnt = o_cnt;
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      if (o_d !== d || o_nv !== nv || o_cnt != cnt || o_ov !== 1'b1) stab_ok = 0;
    end
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    if (o_ov !== 1'b0) stab_ok = 0;
  endtask

  task automatic test_reset();
    #12;
    total++; if (h_ov !== 1'b0 || s_ov !== 1'b0) begin bad++; $display("FAIL reset out_valid: got %b/%b want 0/0", h_ov, s_ov); end
    total++; if (h_od !== 16'h7E00 || s_od !== 32'h7FC00000) begin bad++; $display("FAIL reset out_data: got %h/%h want 7e00/7fc00000", h_od, s_od); end
    total++; if (h_nv !== 1'b0 || s_nv !== 1'b0 || h_cnt !== 2'd0 || s_cnt !== 4'd0) begin bad++; $display("FAIL reset nv/count: got %b %b %0d %0d want 0 0 0 0", h_nv, s_nv, h_cnt, s_cnt); end
    @(negedge clk); rst = 0;
    @(negedge clk);
    total++; if (h_ir !== 1'b1 || s_ir !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %b/%b want 1/1", h_ir, s_ir); end
  endtask

  task automatic test_directed();
    logic [31:0] v[$];
    logic [31:0] d, er;
    bit mx, nv, env, lat, stab;
    int cnt, ecnt;
    for (int k = 0; k < 8; k++) begin
      case (k)
        0: begin v = '{32'h3C00, 32'h4000, 32'hBC00}; mx = 1; end
        1: begin v = '{32'h0000, 32'h8000}; mx = 0; end
        2: begin v = '{32'h0000, 32'h8000}; mx = 1; end
        3: begin v = '{32'h7E00, 32'h3C00, 32'h7D00}; mx = 0; end
        4: begin v = '{32'h7E00}; mx = 0; end
        5: begin v = '{32'h8000, 32'h0000}; mx = 0; end
        6: begin v = '{32'h7C00, 32'hFC00, 32'h3C00, 32'h7D00, 32'hBC00, 32'h0000}; mx = 0; end
        default: begin v = '{32'h7D00, 32'h7D00}; mx = 1; end
      endcase
      foreach (v[i]) v[i] = conv(v[i]);
      model(v, mx, er, env, ecnt);
      run_vector(v, mx, d, nv, cnt, lat, stab);
      total++; if (d !== er) begin bad++; $display("FAIL dir%0d/w%0d data: got %h want %h", k, sel, d, er); end
      total++; if (nv !== env || cnt != ecnt) begin bad++; $display("FAIL dir%0d/w%0d nv/count: got %b/%0d want %b/%0d", k, sel, nv, cnt, env, ecnt); end
      total++; if (!lat || !stab) begin bad++; $display("FAIL dir%0d/w%0d timing: got lat=%b stab=%b want 1/1", k, sel, lat, stab); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] er, d;
    bit env;
    int ecnt;
    logic [31:0] v[$];
    @(negedge clk); in_valid = 1; in_data = conv(32'h3C00); in_last = 0; in_max = 1;
    @(negedge clk); in_data = conv(32'h4000); in_last = 1; in_max = 0;
    @(negedge clk); in_data = conv(32'h7C00); in_max = 0; in_last = 1; out_ready = 0;
    v = '{conv(32'h3C00), conv(32'h4000)};
    model(v, 1, er, env, ecnt);
    repeat (5) begin
      total++; if (o_ir !== 1'b0 || o_ov !== 1'b1 || o_d !== er) begin bad++; $display("FAIL bp/w%0d hold: got ir=%b ov=%b d=%h want 0 1 %h", sel, o_ir, o_ov, o_d, er); end
      @(negedge clk);
    end
    out_ready = 1; in_data = conv(32'h3C00); in_last = 0; in_max = 0;
    @(negedge clk);
    out_ready = 0;
    total++; if (o_ov !== 1'b0 || o_ir !== 1'b1) begin bad++; $display("FAIL bp/w%0d release: got ov=%b ir=%b want 0 1", sel, o_ov, o_ir); end
    @(negedge clk); in_data = conv(32'h4000); in_last = 1; in_max = 1;
    @(negedge clk); in_valid = 0;
    model(v, 0, er, env, ecnt);
    d = o_d;
    total++; if (o_ov !== 1'b1 || d !== er || o_cnt != ecnt) begin bad++; $display("FAIL bp/w%0d next: got ov=%b d=%h cnt=%0d want 1 %h %0d", sel, o_ov, d, o_cnt, er, ecnt); end
    out_ready = 1;
    @(negedge clk); out_ready = 0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    bit nv, lat, stab;
    int cnt;
    @(negedge clk); in_valid = 1; in_data = conv(32'h3C00); in_last = 0; in_max = 0;
    @(negedge clk); in_data = conv(32'hBC00);
    @(negedge clk); in_valid = 0;
    #2 rst = 1;
    #1;
    total++; if (o_ov !== 1'b0 || o_d !== cnan() || o_nv !== 1'b0 || o_cnt != 0) begin bad++; $display("FAIL rstmid/w%0d async: got ov=%b d=%h nv=%b cnt=%0d want 0 %h 0 0", sel, o_ov, o_d, o_nv, o_cnt, cnan()); end
    @(negedge clk); rst = 0;
    @(negedge clk);
    total++; if (o_ir !== 1'b1 || o_ov !== 1'b0) begin bad++; $display("FAIL rstmid/w%0d release: got ir=%b ov=%b want 1 0", sel, o_ir, o_ov); end
    run_vector('{conv(32'h7C00)}, 1, d, nv, cnt, lat, stab);
    total++; if (d !== conv(32'h7C00) || cnt != 1 || nv !== 1'b0 || !lat) begin bad++; $display("FAIL rstmid/w%0d inf: got d=%h cnt=%0d nv=%b lat=%b want %h 1 0 1", sel, d, cnt, nv, lat, conv(32'h7C00)); end
  endtask

  task automatic test_random();
    logic [31:0] v[$];
    logic [31:0] d, er;
    bit mx, nv, env, lat, stab;
    int cnt, ecnt;
    for (int k = 0; k < 30; k++) begin
      v = {};
      repeat ($urandom_range(1, 20)) v.push_back(rnd_elem());
      mx = 1'($urandom);
      model(v, mx, er, env, ecnt);
      run_vector(v, mx, d, nv, cnt, lat, stab);
      total++; if (d !== er || nv !== env || cnt != ecnt || !lat || !stab) begin bad++; $display("FAIL rand%0d/w%0d: got d=%h nv=%b cnt=%0d lat=%b stab=%b want %h %b %0d 1 1", k, sel, d, nv, cnt, lat, stab, er, env, ecnt); end
    end
  endtask

  initial begin
    in_valid = 0; in_last = 0; in_max = 0; out_ready = 0; in_data = 0; sel = 0;
    test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_random();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/float_minmax_reduce.md
# float_minmax_reduce

Streaming, parametrised floating-point min/max reduction unit. It accepts a vector of IEEE-754 operands one element per cycle over a valid/ready handshake and accumulates a running minimum or maximum. It returns one result per vector with an invalid-operation flag and an element count. It sits behind the vector issue path as the FPU's reduction engine and covers half and single precision through parameters.

## Interface
- FLOAT_WIDTH, 16, total operand width
- EXPONENT_WIDTH, 5, exponent field width
- FRACTION_WIDTH, 10, fraction field width (FLOAT_WIDTH = 1 + EXPONENT_WIDTH + FRACTION_WIDTH)
- COUNT_WIDTH, 8, element counter width
- CLK  input  1  clock; one clock domain
- RST  input  1  reset, asynchronous, active-high
- in_valid  input  1  element present
- in_ready  output  1  unit can accept an element
- in_data  input  FLOAT_WIDTH  element
- in_last  input  1  final element of the vector
- in_max  input  1  1 = max, 0 = min; sampled on the first beat of a vector only
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  FLOAT_WIDTH  reduced value
- out_nv  output  1  a signalling NaN was seen in the vector
- out_count  output  COUNT_WIDTH  elements accepted, saturating at all-ones

## Operation
- A beat is in_valid && in_ready.
- FSM states:
  - IDLE: no vector open. A beat moves to ACCUM, or to DONE if in_last.
  - ACCUM: vector open. A beat with in_last moves to DONE.
  - DONE: result held. out_valid && out_ready moves to IDLE.
- in_ready = (state != DONE).
- Accumulator identity is the canonical NaN (sign 0, exponent all ones, fraction MSB 1). It is loaded in IDLE, so the first beat yields that element.
- Each beat: acc <= cmp(acc, in_data, mode). The mode register loads in_max on the IDLE beat and holds for the vector.
- cmp follows the RISC-V fmin/fmax rules:
  - Exactly one operand NaN: return the other.
  - Both NaN: return the canonical NaN.
  - -0 is less than +0.
  - Infinities order normally.
  - Any sNaN operand (exponent all ones, fraction nonzero, fraction MSB 0) sets the sticky nv bit.
  - Ordering: sign-magnitude comparison of the raw bit patterns after the NaN checks.
- Counter behaviour:
  - Cleared on the IDLE beat, then set to 1.
  - Incremented per beat.
  - Saturates at 2^COUNT_WIDTH-1; data is still reduced after saturation.
- nv is cleared at vector start.
- Single-element vector (in_last on the IDLE beat): result = that element, or the canonical NaN if the element is NaN.

## Timing
- Reset values:
  - state = IDLE
  - out_valid = 0
  - out_data = canonical NaN
  - out_nv = 0
  - out_count = 0
  - in_ready = 1 one cycle after RST deasserts
- Throughput: one element per cycle while in IDLE/ACCUM.
- Latency: a last beat at edge t gives out_valid = 1 after edge t; out_data, out_nv and out_count are registered and stable until the handshake.
- out_valid is held with stable data until out_ready. Results are never dropped.
- The next vector's first beat is accepted no earlier than the cycle after the output handshake (one bubble per vector).
- in_max, in_last and in_data are ignored when in_valid = 0 or state = DONE.
- RST mid-vector or in DONE: the partial vector and any pending result are discarded; all outputs return to reset values immediately (asynchronous).
- No combinational path from out_ready to in_ready, and none from in_valid to out_valid.

## Structure
- Add to fpu_types_pkg:
  - SINGLE_FLOAT_W, SINGLE_EXPONENT_W, SINGLE_FRACTION_W
  - SINGLE_NAN
  - a reduction-state enum (IDLE, ACCUM, DONE)
- The existing HALF_* constants remain the source for the defaults.
- One combinational sub-module, float_minmax_cmp:
  - parametrised on the same three widths
  - inputs a, b, max
  - outputs res, nv (sNaN seen)
  - it is reused elsewhere.
- The top module holds the FSM, accumulator, mode, nv, counter and output registers.

## Test plan
Half-precision values used: 1.0 = 0x3C00, 2.0 = 0x4000, -1.0 = 0xBC00, +0 = 0x0000, -0 = 0x8000, +inf = 0x7C00, qNaN = 0x7E00, sNaN = 0x7D00.
- Max of {0x3C00, 0x4000, 0xBC00}, last on the third beat -> out_data = 0x4000, out_count = 3, out_nv = 0, out_valid one cycle after the third beat.
- Min of {0x0000, 0x8000} -> out_data = 0x8000; max of the same -> out_data = 0x0000.
- Min of {0x7E00, 0x3C00, 0x7D00} -> out_data = 0x3C00, out_nv = 1. Vector {0x7E00} alone -> out_data = 0x7E00, out_nv = 0, out_count = 1.
- Back-pressure: result ready, out_ready low for 5 cycles while in_valid is held high -> in_ready = 0 and out_data stable throughout. After the handshake, the new vector's first beat is accepted one cycle later and in_max is re-sampled.
- RST pulse after 2 beats of an open vector -> out_valid = 0 and in_ready = 1 after release. A new vector {0x7C00} with max yields 0x7C00, out_count = 1.
- COUNT_WIDTH = 2 with a 6-element vector -> out_count = 3 (saturated) and the correct min/max over all 6 elements. The same directed cases are rerun at single precision (FLOAT_WIDTH = 32).
